// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, next-PC
// select codes and instruction-field constants.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_t;

  typedef enum logic [1:0] {
    PC_SEL_HOLD  = 2'd0,
    PC_SEL_INC   = 2'd1,
    PC_SEL_REDIR = 2'd2,
    PC_SEL_PEND  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  // Instruction addresses are word aligned; low two bits are always zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Next-PC selection for the fetch stage: hold, sequential step, immediate
// redirect target or deferred redirect target, always word aligned.
module if_pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redir_pc,
  input  pc_sel_t     pc_sel,
  output logic [31:0] pc_next
);

  // Select the source of the next PC and force word alignment.
  always_comb begin
    pc_next = pc;
    unique case (pc_sel)
      PC_SEL_HOLD:  pc_next = pc;
      PC_SEL_INC:   pc_next = pc + PC_STEP;
      PC_SEL_REDIR: pc_next = redirect_pc;
      PC_SEL_PEND:  pc_next = redir_pc;
      default:      pc_next = pc;
    endcase
    pc_next = word_align(pc_next);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches from instruction memory with
// a req/ready handshake and holds one instruction for the decoder with a
// valid/ready handshake. Redirects arriving mid-access are deferred until the
// access completes so the memory address stays stable.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  if_state_t   state, next_state;
  pc_sel_t     pc_sel;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redir_pending;
  logic [31:0] redir_pc;
  logic        set_pend;
  logic        clr_pend;
  logic        capture;
  logic        drop_valid;
  logic        fire;

  assign imem_addr = pc;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign fire      = imem_req & imem_ready;

  if_pc_next u_pc_next (
    .pc          (pc),
    .redirect_pc (redirect_pc),
    .redir_pc    (redir_pc),
    .pc_sel      (pc_sel),
    .pc_next     (pc_next)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state and control decode; redirect_valid takes priority everywhere.
  always_comb begin
    next_state = state;
    pc_sel     = PC_SEL_HOLD;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    capture    = 1'b0;
    drop_valid = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          // Retarget now if no access is outstanding or it finishes this
          // cycle; otherwise park the target until the access completes.
          if (!imem_req || imem_ready) begin
            pc_sel   = PC_SEL_REDIR;
            clr_pend = 1'b1;
          end else begin
            set_pend = 1'b1;
          end
        end else if (fire) begin
          if (redir_pending) begin
            pc_sel   = PC_SEL_PEND;
            clr_pend = 1'b1;
          end else begin
            pc_sel     = PC_SEL_INC;
            capture    = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel     = PC_SEL_REDIR;
          drop_valid = 1'b1;
          next_state = FETCH;
        end else if (id_ready) begin
          drop_valid = 1'b1;
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  // PC, deferred redirect and held-instruction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= word_align(PC_RESET);
      imem_req      <= 1'b0;
      redir_pending <= 1'b0;
      redir_pc      <= '0;
      instr_valid   <= 1'b0;
      instr         <= NOP_INSTR;
      pc_out        <= '0;
      pc_plus4      <= PC_STEP;
    end else begin
      pc       <= pc_next;
      imem_req <= (next_state == FETCH);
      if (set_pend) begin
        redir_pending <= 1'b1;
        redir_pc      <= word_align(redirect_pc);
      end else if (clr_pend) begin
        redir_pending <= 1'b0;
      end
      if (capture) begin
        instr       <= imem_rdata;
        pc_out      <= pc;
        pc_plus4    <= pc + PC_STEP;
        instr_valid <= 1'b1;
      end else if (drop_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a cycle-level behavioural model tracks
// the expected request/address/valid outputs, and every accepted fetch pushes
// its expected instruction onto a scoreboard checked while it is held.
module tb_instr_fetch;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4;
  logic [5:0]  opcode;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc_out, w_pc_plus4;
  logic [5:0]  w_opcode;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit          m_known = 0;
  bit          m_in_reset = 0;
  bit          m_fetch = 1;
  bit          m_req = 0;
  bit          m_valid = 0;
  bit          m_pend = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_rpc = '0;
  sb_entry_t   sb[$];

  logic [31:0] wrap_addr[2];
  int          wrap_n = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    op = 6'h23 + a[7:2];
    return {op, a[27:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  instr_fetch #(.PC_RESET(32'h0000_0000)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4)
  );

  instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (w_rdata),
    .id_ready       (id_ready),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .instr_valid    (w_valid),
    .instr          (w_instr),
    .opcode         (w_opcode),
    .pc_out         (w_pc_out),
    .pc_plus4       (w_pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model using the
  // inputs the DUT will see at the next rising edge, then step past it.
  task automatic tick();
    sb_entry_t e;
    @(negedge clk);
    if (m_known) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      if (m_in_reset) begin
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", {26'b0, opcode}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'h0, 32'h1);
        end else begin
          e = sb[0];
          chk("instr", instr, e.word);
          chk("opcode", {26'b0, opcode}, {26'b0, e.word[31:26]});
          chk("pc_out", pc_out, e.pc);
          chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
      if (rst_n && w_req && imem_ready && wrap_n < 2) begin
        wrap_addr[wrap_n] = w_addr;
        wrap_n++;
      end
    end

    if (!rst_n) begin
      m_known = 1; m_in_reset = 1;
      m_fetch = 1; m_req = 0; m_valid = 0; m_pend = 0;
      m_pc = 32'h0; m_rpc = 32'h0;
      sb.delete();
    end else if (m_known) begin
      m_in_reset = 0;
      if (m_fetch) begin
        if (redirect_valid) begin
          if (!m_req || imem_ready) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            m_pend = 0;
          end else begin
            m_pend = 1;
            m_rpc = {redirect_pc[31:2], 2'b00};
          end
        end else if (m_req && imem_ready) begin
          if (m_pend) begin
            m_pc = m_rpc;
            m_pend = 0;
          end else begin
            e.pc = m_pc;
            e.word = mem_word(m_pc);
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
            m_fetch = 0;
            m_valid = 1;
          end
        end
      end else begin
        if (redirect_valid || id_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_fetch = 1;
          m_valid = 0;
          if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
        end
      end
      m_req = m_fetch;
    end
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until the model expects an outstanding memory request.
  task automatic align_fetch();
    int n;
    n = 0;
    while (!(m_fetch && m_req) && n < 20) begin
      tick();
      n++;
    end
    if (!(m_fetch && m_req)) chk("align_fetch", 32'h0, 32'h1);
  endtask

  task automatic align_hold();
    int n;
    n = 0;
    imem_ready = 1; id_ready = 0;
    while (m_fetch && n < 20) begin
      tick();
      n++;
    end
    if (m_fetch) chk("align_hold", 32'h0, 32'h1);
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; id_ready = 1; redirect_valid = 0; redirect_pc = '0;
    tick(); tick();

    // zero-wait streaming
    rst_n = 1; imem_ready = 1; id_ready = 1;
    for (int i = 0; i < 12; i++) tick();

    // memory wait of three cycles
    imem_ready = 0;
    align_fetch();
    tick(); tick(); tick();
    imem_ready = 1;
    tick();

    // downstream backpressure for five cycles
    align_hold();
    for (int i = 0; i < 5; i++) tick();
    id_ready = 1;
    tick(); tick(); tick();

    // redirect to an unaligned target during a waited fetch
    imem_ready = 0;
    align_fetch();
    redirect_valid = 1; redirect_pc = 32'h0000_1003;
    tick();
    redirect_valid = 0; redirect_pc = '0;
    tick();
    imem_ready = 1; id_ready = 1;
    tick(); tick(); tick();

    // redirect in HOLD together with id_ready
    align_hold();
    tick();
    redirect_valid = 1; redirect_pc = 32'h0000_0200; id_ready = 1;
    tick();
    redirect_valid = 0;
    tick(); tick(); tick();

    // redirect in HOLD without id_ready drops the instruction
    align_hold();
    redirect_valid = 1; redirect_pc = 32'h0000_0340;
    tick();
    redirect_valid = 0; id_ready = 1;
    tick(); tick(); tick();

    // reset in the middle of a waited access
    imem_ready = 0;
    align_fetch();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick(); tick();
    imem_ready = 1;
    tick(); tick();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      imem_ready     = ($urandom_range(0, 99) < 60);
      id_ready       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 12);
      redirect_pc    = $urandom & 32'h0000_0FFF;
      rst_n          = ($urandom_range(0, 99) >= 2);
      tick();
    end
    rst_n = 1; redirect_valid = 0;

    if (wrap_n < 2) begin
      chk("wrap_seen", 32'h0, 32'h1);
    end else begin
      chk("wrap_addr0", wrap_addr[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", wrap_addr[1], 32'h0000_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
